// File: rtl/aud_voice_arbiter_if.sv
// Bundle between the voice engines, the shared sample memory and the
// voice arbiter. The arbiter connects through the slave view. The voice
// engines and the memory connect through the master view.
interface aud_voice_arbiter_if #(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8
);
  logic [NUM_VOICES-1:0]        req;
  logic [NUM_VOICES*ADDR_W-1:0] req_addr;
  logic [NUM_VOICES-1:0]        gnt;
  logic                         mem_en;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_rdata;
  logic [NUM_VOICES-1:0]        rsp_valid;
  logic [DATA_W-1:0]            rsp_data;
  logic [NUM_VOICES-1:0]        leds;

  modport slave (
    input  req, req_addr, mem_rdata,
    output gnt, mem_en, mem_addr, rsp_valid, rsp_data, leds
  );

  modport master (
    output req, req_addr, mem_rdata,
    input  gnt, mem_en, mem_addr, rsp_valid, rsp_data, leds
  );
endinterface

// File: rtl/aud_voice_arbiter.sv
// Round-robin arbiter that shares one pipelined read-only sample memory
// between NUM_VOICES voice engines. It issues at most one read per cycle.
// A {valid, id} shift register tracks the reads that are in flight, so
// each sample returns to the voice that requested it. Each voice also
// has a stretched activity LED.
module aud_voice_arbiter #(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int MEM_LAT    = 2,
  parameter int LED_HOLD   = 5000000
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  aud_voice_arbiter_if.slave   bus
);

  localparam int ID_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int LED_W = $clog2(LED_HOLD + 1);
  localparam logic [LED_W-1:0] LED_RELOAD = LED_W'(LED_HOLD);
  localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_VOICES - 1);

  // Voice index reached 'off' steps above 'base', wrapping at NUM_VOICES.
  function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_VOICES) begin
      sum = sum - NUM_VOICES;
    end else begin
      sum = sum;
    end
    return ID_W'(sum);
  endfunction

  logic [ID_W-1:0]       ptr_r;
  logic [ID_W-1:0]       ptr_next_s;
  logic [ID_W-1:0]       win_id_s;
  logic                  found_s;
  logic                  grant_s;
  logic [NUM_VOICES-1:0] gnt_s;
  logic [ADDR_W-1:0]     mem_addr_s;

  logic [MEM_LAT-1:0]    pipe_vld_r;
  logic [ID_W-1:0]       pipe_id_r [MEM_LAT];
  logic [NUM_VOICES-1:0] rsp_valid_s;
  logic [DATA_W-1:0]     rsp_data_s;

  logic [LED_W-1:0]      led_cnt_r      [NUM_VOICES];
  logic [LED_W-1:0]      led_cnt_next_s [NUM_VOICES];
  logic [NUM_VOICES-1:0] leds_r;

  // Rotating priority search: the first requester at or above ptr wins.
  always_comb begin
    found_s  = 1'b0;
    win_id_s = {ID_W{1'b0}};
    for (int k = 0; k < NUM_VOICES; k++) begin
      win_id_s = (!found_s && bus.req[rot_idx(ptr_r, k)]) ? rot_idx(ptr_r, k) : win_id_s;
      found_s  = found_s | bus.req[rot_idx(ptr_r, k)];
    end
  end

  // Grant decode, memory request and next pointer. Reset masks every grant.
  always_comb begin
    grant_s          = found_s & rst_n;
    gnt_s            = {NUM_VOICES{1'b0}};
    gnt_s[win_id_s]  = grant_s;
    mem_addr_s       = grant_s ? bus.req_addr[int'(win_id_s)*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}};
    ptr_next_s       = grant_s ? ((win_id_s == LAST_ID) ? {ID_W{1'b0}} : win_id_s + ID_W'(1)) : ptr_r;
  end

  // Round-robin pointer: moves past the winner and holds when nothing is granted.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {ID_W{1'b0}};
    end else begin
      ptr_r <= ptr_next_s;
    end
  end

  // Tracks in-flight reads. Its depth equals the memory latency, so the
  // last stage lines up with mem_rdata.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_r <= {MEM_LAT{1'b0}};
      for (int s = 0; s < MEM_LAT; s++) begin
        pipe_id_r[s] <= {ID_W{1'b0}};
      end
    end else begin
      pipe_vld_r[0] <= grant_s;
      pipe_id_r[0]  <= win_id_s;
      for (int s = 1; s < MEM_LAT; s++) begin
        pipe_vld_r[s] <= pipe_vld_r[s-1];
        pipe_id_r[s]  <= pipe_id_r[s-1];
      end
    end
  end

  // Steers the returning sample to its requester. Data is zero when no read completes.
  always_comb begin
    rsp_valid_s                           = {NUM_VOICES{1'b0}};
    rsp_valid_s[pipe_id_r[MEM_LAT-1]]     = pipe_vld_r[MEM_LAT-1];
    rsp_data_s = pipe_vld_r[MEM_LAT-1] ? bus.mem_rdata : {DATA_W{1'b0}};
  end

  // LED hold counters: a grant reloads the full hold, otherwise count down to zero.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      led_cnt_next_s[i] = gnt_s[i] ? LED_RELOAD :
                          ((led_cnt_r[i] != {LED_W{1'b0}}) ? led_cnt_r[i] - LED_W'(1) : {LED_W{1'b0}});
    end
  end

  // LED state registers. The lamp flop uses the next count, so it lights
  // in the cycle right after the grant.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      leds_r <= {NUM_VOICES{1'b0}};
      for (int i = 0; i < NUM_VOICES; i++) begin
        led_cnt_r[i] <= {LED_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        led_cnt_r[i] <= led_cnt_next_s[i];
        leds_r[i]    <= (led_cnt_next_s[i] != {LED_W{1'b0}});
      end
    end
  end

  assign bus.gnt       = gnt_s;
  assign bus.mem_en    = grant_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_data  = rsp_data_s;
  assign bus.leds      = leds_r;

endmodule

// File: doc/aud_voice_arbiter.md
Name: aud_voice_arbiter

Overview:
- Round-robin arbiter that shares one pipelined, read-only sample memory port between NUM_VOICES audio voice engines.
- Each voice engine feeds one PWM audio output and fetches waveform samples through this block.
- The block grants at most one read per cycle, issues it to memory, and routes each returned sample back to its requester.
- It also drives per-voice activity LEDs, stretched so they are visible on the board.

Parameters:
- NUM_VOICES, 4, number of requesting voice engines (2..8)
- ADDR_W, 16, sample memory address width
- DATA_W, 8, sample width
- MEM_LAT, 2, fixed memory read latency in cycles from mem_en to mem_rdata valid (1..4)
- LED_HOLD, 5000000, activity LED on-time in cycles after a grant (100 ms at 50 MHz sysclk)

Ports:
- sysclk  in  1  system clock, 50 MHz
- rst_n  in  1  reset; asynchronous, active-low
- req  in  NUM_VOICES  per-voice read request, level
- req_addr  in  NUM_VOICES*ADDR_W  per-voice address; voice i occupies bits [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_VOICES  one-hot grant, combinational, same cycle as req
- mem_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- rsp_valid  out  NUM_VOICES  one-hot response strobe, one cycle
- rsp_data  out  DATA_W  response sample, broadcast to all voices, qualified by rsp_valid
- leds  out  NUM_VOICES  stretched per-voice activity indicator

Behaviour:
- Reset (rst_n low, asynchronous):
  - rr pointer = 0, so voice 0 has highest priority.
  - Response pipeline cleared, so in-flight reads are dropped.
  - LED counters = 0.
  - Outputs while reset is held: gnt=0, mem_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, leds=0.
- Handshake:
  - A voice raises req with a stable req_addr and holds both until it sees gnt[i]=1 at a rising edge.
  - A grant is consumed in that cycle.
  - If req[i] is still high in the following cycle, it is a new request and may be granted again.
- Arbitration, combinational:
  - Search order starts at ptr and ascends modulo NUM_VOICES.
  - The first asserted req wins; gnt is one-hot or all-zero.
  - mem_en = |gnt; mem_addr = req_addr of the winner, else 0.
- Pointer update:
  - On any grant to voice k, ptr <= (k+1) mod NUM_VOICES.
  - With no grant, ptr holds.
  - Any continuously requesting voice therefore waits at most NUM_VOICES-1 cycles.
- Response pipeline:
  - MEM_LAT-deep shift register of {valid, voice id}, loaded with {mem_en, winner id} each cycle.
  - At the output: rsp_valid = onehot(id) when valid, else 0; rsp_data = mem_rdata when valid, else 0.
  - Latency is exactly MEM_LAT cycles from gnt to rsp_valid.
  - Responses are delivered in grant order, and back-to-back responses are supported every cycle.
- LEDs:
  - Per-voice down-counter of width clog2(LED_HOLD+1).
  - gnt[i] reloads it to LED_HOLD; otherwise it decrements and saturates at 0.
  - leds[i] = (counter != 0), registered.
  - A regrant while the LED is lit restarts the full hold.
- Simultaneous events: the grant and the response of a different (or the same) voice in one cycle are independent, and both occur.
- Reset mid-operation: all pending rsp_valid are suppressed; the first grant after release goes to the lowest-index requester.

Test Plan:
- Reset check: hold rst_n=0 with req=4'b1111 -> gnt=0, mem_en=0, rsp_valid=0, leds=0. Release -> gnt=4'b0001 in the first cycle.
- Single voice streaming: req=4'b0100 held, addresses 0x10, 0x11, 0x12 on consecutive cycles, memory model returns addr[7:0] with MEM_LAT=2 -> gnt[2] every cycle; rsp_valid=4'b0100 with rsp_data 0x10, 0x11, 0x12 starting exactly 2 cycles after the first gnt.
- Full contention: req=4'b1111 held for 12 cycles -> grant order 0,1,2,3,0,1,2,3,0,1,2,3; each voice gets exactly 3 grants; responses mirror the same order 2 cycles later.
- Sparse fairness: req=4'b1010 held, ptr=0 -> grants 1,3,1,3. Then add req[0] after a grant to 3 -> next grant is 0, then 1.
- LED stretch (LED_HOLD=4): single grant to voice 1 -> leds[1] high for exactly 4 cycles. A second grant at cycle 2 keeps leds[1] high until 4 cycles after the second grant.
- Reset mid-flight: grant voice 3, assert rst_n=0 one cycle later -> no rsp_valid[3] ever appears. After release with req=4'b1000 -> gnt=4'b1000 and a response MEM_LAT cycles later.
